// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the 64-bit ALU.
// Each request is resolved one amount bit per cycle in log-stage order
// (stage k shifts by 2^k when amount bit k is set), giving a fixed latency
// of K cycles from accept to result. Supports SLL/SRL/SRA and, when N == 64,
// the RV64 word variants.
module shift_sequencer #(
  parameter int N = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [1:0]             op,
  input  logic                   word,
  input  logic [$clog2(N)-1:0]   shift_amount,
  input  logic [N-1:0]           dataIn,
  output logic [N-1:0]           dataOut,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int K = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_n_s;

  logic [N-1:0]   work_r;
  logic [K-1:0]   amt_r;      // consumed LSB-first, one bit per stage
  logic [K-1:0]   dist_r;     // 2^k for the current stage k
  logic [K-1:0]   k_r;
  logic [1:0]     op_r;
  logic           word_r;
  logic [N-1:0]   dataout_r;
  logic           out_valid_r;
  logic           busy_r;

  logic           accept_s;
  logic           last_stage_s;
  logic           word_eff_s;
  logic [N-1:0]   prep_data_s;
  logic [K-1:0]   prep_amt_s;
  logic [N-1:0]   stage_s;
  logic [N-1:0]   fin_s;

  assign start_ready  = (state_r == IDLE) && !rst;
  assign accept_s     = start_valid && start_ready;
  assign last_stage_s = (k_r == K'(K - 1));
  assign dataOut      = dataout_r;
  assign out_valid    = out_valid_r;
  assign busy         = busy_r;

  // Word-variant handling only exists for the 64-bit configuration.
  generate
    if (N == 64) begin : g_word
      assign word_eff_s = word;

      // Operand and amount preparation at accept time for word ops.
      always_comb begin
        prep_data_s = dataIn;
        prep_amt_s  = shift_amount;
        if (word) begin
          prep_amt_s = {1'b0, shift_amount[4:0]};
          if (op == 2'b11) begin
            prep_data_s = {{32{dataIn[31]}}, dataIn[31:0]};
          end else begin
            prep_data_s = {32'h0000_0000, dataIn[31:0]};
          end
        end else begin
          prep_amt_s  = shift_amount;
        end
      end

      // Word results are sign-extended from bit 31 on the way out.
      always_comb begin
        fin_s = stage_s;
        if (word_r) begin
          fin_s = {{32{stage_s[31]}}, stage_s[31:0]};
        end else begin
          fin_s = stage_s;
        end
      end
    end else begin : g_noword
      assign word_eff_s  = 1'b0;
      assign prep_data_s = dataIn;
      assign prep_amt_s  = shift_amount;
      assign fin_s       = stage_s;
    end
  endgenerate

  // One log-shifter stage: shift by dist_r when the current amount bit is set.
  always_comb begin
    stage_s = work_r;
    if (amt_r[0]) begin
      case (op_r)
        2'b01:   stage_s = work_r >> dist_r;
        2'b11:   stage_s = $unsigned($signed(work_r) >>> dist_r);
        default: stage_s = work_r << dist_r;
      endcase
    end else begin
      stage_s = work_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = SHIFT;
        end else begin
          state_n_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_stage_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath: latch request, step stages, register result and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r      <= {N{1'b0}};
      amt_r       <= {K{1'b0}};
      dist_r      <= {K{1'b0}};
      k_r         <= {K{1'b0}};
      op_r        <= 2'b00;
      word_r      <= 1'b0;
      dataout_r   <= {N{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_n_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            work_r <= prep_data_s;
            amt_r  <= prep_amt_s;
            dist_r <= K'(1'b1);
            k_r    <= {K{1'b0}};
            op_r   <= op;
            word_r <= word_eff_s;
          end
        end
        SHIFT: begin
          work_r <= stage_s;
          amt_r  <= amt_r >> 1;
          dist_r <= dist_r << 1;
          k_r    <= k_r + K'(1'b1);
          if (last_stage_s) begin
            dataout_r   <= fin_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (N = 64): directed cases from the
// test plan plus randomized requests scored against an arithmetic model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic        word;
  logic [5:0]  shift_amount;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  shift_sequencer #(.N(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .word         (word),
    .shift_amount (shift_amount),
    .dataIn       (data_in),
    .dataOut      (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain RISC-V shift semantics.
  function automatic logic [63:0] ref_shift(input logic [1:0] o, input logic w,
                                            input logic [5:0] a, input logic [63:0] d);
    logic [31:0] x;
    logic [63:0] r;
    int s;
    if (w) begin
      s = int'(a) % 32;
      x = d[31:0];
      case (o)
        2'b01:   x = x >> s;
        2'b11:   x = $signed(x) >>> s;
        default: x = x << s;
      endcase
      r = {{32{x[31]}}, x};
    end else begin
      s = int'(a);
      case (o)
        2'b01:   r = d >> s;
        2'b11:   r = $signed(d) >>> s;
        default: r = d << s;
      endcase
    end
    return r;
  endfunction

  // One full transaction. hold = DONE cycles with out_ready low;
  // pulse = spam a different request during those cycles.
  task automatic run_req(input string tag, input logic [1:0] o, input logic w,
                         input logic [5:0] a, input logic [63:0] d,
                         input logic [63:0] exp, input int hold, input bit pulse);
    int cyc;
    @(negedge clk);
    check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    start_valid  = 1'b1;
    op           = o;
    word         = w;
    shift_amount = a;
    data_in      = d;
    @(posedge clk);
    @(negedge clk);
    start_valid  = 1'b0;
    op           = 2'($urandom);
    word         = 1'($urandom);
    shift_amount = 6'($urandom);
    data_in      = {$urandom, $urandom};
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!out_valid) begin
        out_ready    = 1'($urandom);
        shift_amount = 6'($urandom);
        data_in      = {$urandom, $urandom};
      end else begin
        out_ready = 1'b0;
      end
    end
    out_ready = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd6);
    check({tag, "_data"}, data_out, exp);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        start_valid  = 1'(i % 2);
        op           = 2'b01;
        word         = 1'b0;
        shift_amount = 6'd1;
        data_in      = ~d;
      end
      @(negedge clk);
      check({tag, "_hold_data"}, data_out, exp);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      if (pulse) begin
        check({tag, "_hold_ready"}, 64'(start_ready), 64'd0);
      end
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    out_ready   = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check({tag, "_post_ready"}, 64'(start_ready), 64'd1);
    if (pulse) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check({tag, "_no_second"}, {62'd0, busy, out_valid}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic        rw;
    logic [5:0]  ra;
    logic [63:0] rd;
    bit          seen_valid;

    rst          = 1'b1;
    start_valid  = 1'b0;
    op           = 2'b00;
    word         = 1'b0;
    shift_amount = 6'd0;
    data_in      = 64'd0;
    out_ready    = 1'b0;
    #2;
    check("rst_start_ready", 64'(start_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_start_ready", 64'(start_ready), 64'd1);

    run_req("sra",      2'b11, 1'b0, 6'd4,  64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000, 0, 1'b0);
    run_req("sllw",     2'b00, 1'b1, 6'd1,  64'h0000_0000_4000_0001, 64'hFFFF_FFFF_8000_0002, 1, 1'b0);
    run_req("srlw",     2'b01, 1'b1, 6'h3F, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_0001, 0, 1'b0);
    run_req("sraw",     2'b11, 1'b1, 6'd31, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_req("sll0",     2'b00, 1'b0, 6'd0,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
    run_req("op10",     2'b10, 1'b0, 6'd63, 64'h0000_0000_0000_0003, 64'h8000_0000_0000_0000, 0, 1'b0);
    run_req("backpres", 2'b01, 1'b0, 6'd8,  64'hA5A5_0000_1111_2222, 64'h00A5_A500_0011_1122, 10, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      rw = 1'($urandom);
      ra = 6'($urandom);
      rd = {$urandom, $urandom};
      run_req("rand", ro, rw, ra, rd, ref_shift(ro, rw, ra, rd), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during stage 3 (stage 3 would execute at the 4th edge after accept).
    @(negedge clk);
    start_valid  = 1'b1;
    op           = 2'b11;
    word         = 1'b0;
    shift_amount = 6'd15;
    data_in      = 64'hF0F0_0000_0000_1234;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_ready", 64'(start_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 64'(start_ready), 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    check("no_stale", 64'(seen_valid), 64'd0);
    run_req("srl_after_rst", 2'b01, 1'b0, 6'd4, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_000F, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
